// File: rtl/ram_x_18_pingpong_pkg.sv
// Shared 18-bit datapath constants for the ping-pong RAM, ROM path and multiplier core.
// Words are unsigned fixed point: 3 integer bits over 15 fraction bits.
package ram_x_18_pingpong_pkg;
  localparam int DATA_W    = 18;
  localparam int INT_BITS  = 3;
  localparam int FRAC_BITS = 15;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/ram_x_18_pingpong_bank.sv
// One simple dual-port bank for the ping-pong RAM.
// It has one write port and one registered read port, coded so block RAM is inferred.
module ram_bank_18
  import ram_x_18_pingpong_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // The power-up contents are all zero, so unwritten words read back as 0.
  data_t mem_q [2**AW] = '{default: '0};
  data_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_x_18_pingpong.sv
// Ping-pong pair of 2^AW x 18 banks.
// The switch input picks which bank takes writes; the other bank is the one that is read.
module ram_x_18_pingpong
  import ram_x_18_pingpong_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic              switch,
  input  logic [AW-1:0]     writeAddr,
  input  logic [DATA_W-1:0] writeData,
  input  logic [AW-1:0]     readAddr,
  output logic [DATA_W-1:0] readData
);

  logic              we_a;
  logic              we_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              sel_q;
  logic              sel_d;
  logic              valid_q;
  logic              valid_d;

  // Writes go only to the write-side bank, and never while reset is held.
  assign we_a = WE & ~RST & ~switch;
  assign we_b = WE & ~RST &  switch;

  ram_bank_18 #(.AW(AW)) u_bank_a (
    .clk_i   (CLK),
    .we_i    (we_a),
    .waddr_i (writeAddr),
    .wdata_i (writeData),
    .raddr_i (readAddr),
    .rdata_o (rd_a)
  );

  ram_bank_18 #(.AW(AW)) u_bank_b (
    .clk_i   (CLK),
    .we_i    (we_b),
    .waddr_i (writeAddr),
    .wdata_i (writeData),
    .raddr_i (readAddr),
    .rdata_o (rd_b)
  );

  assign sel_d   = switch;
  assign valid_d = 1'b1;

  // Both banks read on every edge, so the sampled switch value only has to steer the mux.
  // The valid_q flag clears the output asynchronously during reset without touching either bank.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  // readData depends only on registers, so no input has a combinational path to it.
  assign readData = valid_q ? (sel_q ? rd_a : rd_b) : '0;

endmodule

// File: tb/tb_ram_x_18_pingpong.sv
// Directed and random stimulus for the ping-pong RAM.
// Expected read words come from a two-bank reference model and are queued for checking.
module tb_ram_x_18_pingpong;
  localparam int AW = 10;
  localparam int W  = 18;

  logic          clk;
  logic          rst;
  logic          we;
  logic          sw;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;

  logic [W-1:0] mdl_a [2**AW];
  logic [W-1:0] mdl_b [2**AW];
  logic [W-1:0] exp_q [$];
  int           checks;
  int           errors;
  logic [W-1:0] obs;

  ram_x_18_pingpong #(.AW(AW)) dut (
    .CLK       (clk),
    .RST       (rst),
    .WE        (we),
    .switch    (sw),
    .writeAddr (waddr),
    .writeData (wdata),
    .readAddr  (raddr),
    .readData  (rdata)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, o, e);
    end
  endtask

  // Drives one cycle starting at a negedge. The expected word is queued, then compared at the next negedge.
  task automatic cycle(input logic r, input logic w, input logic s,
                       input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic [AW-1:0] ra, output logic [W-1:0] o);
    logic [W-1:0] e;
    rst = r; we = w; sw = s; waddr = wa; wdata = wd; raddr = ra;
    if (r) begin
      #1;
      check("rst_async", rdata, '0);
      e = '0;
    end else begin
      e = s ? mdl_a[ra] : mdl_b[ra];
    end
    exp_q.push_back(e);
    if (w && !r) begin
      if (s) mdl_b[wa] = wd;
      else   mdl_a[wa] = wd;
    end
    @(posedge clk);
    @(negedge clk);
    o = rdata;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end else begin
      check("sb_read", rdata, exp_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2**AW; i++) begin
      mdl_a[i] = '0;
      mdl_b[i] = '0;
    end
    rst = 1'b1; we = 1'b0; sw = 1'b0; waddr = '0; wdata = '0; raddr = 10'd5;
    repeat (3) @(negedge clk);
    check("powerup_rst", rdata, '0);

    // Release reset and read address 5 from bank B.
    cycle(0, 0, 0, 0, 0, 10'd5, obs);
    check("post_rst_read", obs, 18'h0);

    // Write bank A while reading bank B, then swap the banks.
    cycle(0, 1, 0, 10'd3, 18'h0ABCD, 10'd3, obs);
    check("read_bank_b", obs, 18'h0);
    cycle(0, 0, 1, 0, 0, 10'd3, obs);
    check("swap_read_a", obs, 18'h0ABCD);

    // Write and read the same address number in one cycle.
    cycle(0, 1, 1, 10'd3, 18'h3FFFF, 10'd3, obs);
    check("same_addr_rw", obs, 18'h0ABCD);
    cycle(0, 0, 0, 0, 0, 10'd3, obs);
    check("read_b_3", obs, 18'h3FFFF);

    // Top address.
    cycle(0, 1, 0, 10'd1023, 18'h12345, 10'd0, obs);
    cycle(0, 0, 1, 0, 0, 10'd1023, obs);
    check("top_addr", obs, 18'h12345);
    cycle(0, 0, 1, 0, 0, 10'd0, obs);
    check("addr0_zero", obs, 18'h0);

    // Reset in mid-stream, with writes attempted while it is held.
    cycle(0, 0, 1, 0, 0, 10'd3, obs);
    check("pre_rst", obs, 18'h0ABCD);
    cycle(1, 1, 1, 10'd3, 18'h11111, 10'd3, obs);
    check("in_rst_0", obs, 18'h0);
    cycle(1, 1, 0, 10'd5, 18'h22222, 10'd3, obs);
    check("in_rst_1", obs, 18'h0);
    cycle(1, 0, 0, 0, 0, 10'd3, obs);
    check("in_rst_2", obs, 18'h0);
    cycle(0, 0, 1, 0, 0, 10'd3, obs);
    check("kept_a3", obs, 18'h0ABCD);
    cycle(0, 0, 0, 0, 0, 10'd3, obs);
    check("kept_b3", obs, 18'h3FFFF);
    cycle(0, 0, 1, 0, 0, 10'd5, obs);
    check("no_rst_write", obs, 18'h0);

    // Load k*0x100 into bank A, then stream-read addresses 0..7.
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, AW'(k), W'(k * 256), 10'd0, obs);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 1, 0, 0, AW'(k), obs);
      check("stream", obs, W'(k * 256));
    end

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = ($urandom_range(0, 7) == 0) ? 10'd1023 : AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 7) == 0) ? 10'd1023 : AW'($urandom_range(0, 15));
      cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa,
            W'($urandom_range(0, 18'h3FFFF)), ra, obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
